// File: rtl/fb_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fb_mem_arbiter : single-port framebuffer arbiter (video > host pixel RMW),
//                  optional whole-frame fill engine when FB_CLEAR_EN is defined.
// Rev 1.0
// ----------------------------------------------------------------------------
module fb_mem_arbiter #(
  parameter int WORDS = 384,
  parameter int ROWS  = 48
) (
  input  logic        clk_25,
  input  logic        rst,
  input  logic        vid_read,
  input  logic        vid_row,
  input  logic [8:0]  vid_addr,
  input  logic [2:0]  vid_sel,
  output logic [3:0]  vid_pixel,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [11:0] host_addr,
  input  logic [3:0]  host_wdata,
  output logic [3:0]  host_rdata,
  output logic        host_ack,
  output logic        host_err,
  input  logic        clr_start,
  input  logic [3:0]  clr_colour,
  output logic        clr_busy,
  output logic [8:0]  mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [6:0] c_ROW_LIMIT = 7'(ROWS);

`ifdef FB_CLEAR_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_ACK  = 3'd3,
    S_CLR  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_ACK  = 3'd3
  } state_t;
`endif

  state_t      r_state;
  state_t      w_next;

  logic [8:0]  r_idx;
  logic [2:0]  r_sel;
  logic        r_we;
  logic [3:0]  r_wdata;
  logic        r_err;
  logic [31:0] r_word;
  logic [3:0]  r_rdata;

  logic        w_free;
  logic        w_row_err;
  logic        w_clr_go;
  logic        w_take_host;
  logic [31:0] w_merged;

  assign w_free      = !vid_read && !vid_row;
  assign w_row_err   = ({1'b0, host_addr[11:6]} >= c_ROW_LIMIT);
  assign w_take_host = (r_state == S_IDLE) && host_req && !w_clr_go;

  assign vid_pixel   = mem_rdata[{vid_sel, 2'b00} +: 4];
  assign host_rdata  = r_rdata;
  assign host_ack    = (r_state == S_ACK);
  assign host_err    = host_ack && r_err;

`ifdef FB_CLEAR_EN
  logic [8:0]  r_cnt;
  logic [3:0]  r_colour;
  logic        w_last;

  assign w_clr_go = (r_state == S_IDLE) && clr_start;
  assign w_last   = (r_cnt == 9'(WORDS - 1));
  assign clr_busy = (r_state == S_CLR);

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_colour <= '0;
    end else if (w_clr_go) begin
      r_cnt    <= '0;
      r_colour <= clr_colour;
    end else if (r_state == S_CLR && w_free) begin
      r_cnt    <= w_last ? 9'd0 : r_cnt + 9'd1;
    end
  end
`else
  logic w_unused;

  assign w_clr_go = 1'b0;
  assign clr_busy = 1'b0;
  assign w_unused = ^{clr_start, clr_colour, 9'(WORDS)};
`endif

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_clr_go) begin
`ifdef FB_CLEAR_EN
          w_next = S_CLR;
`endif
        end else if (host_req) begin
          w_next = w_row_err ? S_ACK : S_RD;
        end
      end
      S_RD:  if (w_free) w_next = r_we ? S_WR : S_ACK;
      S_WR:  if (w_free) w_next = S_ACK;
      S_ACK: w_next = S_IDLE;
`ifdef FB_CLEAR_EN
      S_CLR: if (w_free && w_last) w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Request fields are captured once so a host changing the bus mid-stall cannot corrupt the RMW.
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_word  <= '0;
      r_rdata <= '0;
    end else begin
      if (w_take_host) begin
        r_idx   <= host_addr[11:3];
        r_sel   <= host_addr[2:0];
        r_we    <= host_we;
        r_wdata <= host_wdata;
        r_err   <= w_row_err;
      end
      if (r_state == S_RD && w_free) begin
        r_word  <= mem_rdata;
        r_rdata <= mem_rdata[{r_sel, 2'b00} +: 4];
      end
    end
  end

  always_comb begin
    w_merged = r_word;
    w_merged[{r_sel, 2'b00} +: 4] = r_wdata;
  end

  // Video owns the address whenever it reads; writes only ever happen in free cycles.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (vid_read) begin
      mem_addr = vid_addr;
    end else begin
      unique case (r_state)
        S_RD: mem_addr = r_idx;
        S_WR: begin
          mem_addr  = r_idx;
          mem_wdata = w_merged;
          mem_we    = w_free;
        end
`ifdef FB_CLEAR_EN
        S_CLR: begin
          mem_addr  = r_cnt;
          mem_wdata = {8{r_colour}};
          mem_we    = w_free;
        end
`endif
        default: mem_addr = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_mem_arbiter.sv
`default_nettype none
// tb_fb_mem_arbiter: directed, table-driven bench with a behavioural 512x32 memory.
module tb_fb_mem_arbiter;

  logic        clk_25 = 1'b0;
  logic        rst;
  logic        vid_read, vid_row;
  logic [8:0]  vid_addr;
  logic [2:0]  vid_sel;
  logic [3:0]  vid_pixel;
  logic        host_req, host_we;
  logic [11:0] host_addr;
  logic [3:0]  host_wdata, host_rdata;
  logic        host_ack, host_err;
  logic        clr_start;
  logic [3:0]  clr_colour;
  logic        clr_busy;
  logic [8:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [0:511];

  int checks = 0;
  int failures = 0;
  int we_bad = 0, vid_bad = 0, we_cnt = 0, ack_cnt = 0, busy_cnt = 0;

  always #5 clk_25 = ~clk_25;

  fb_mem_arbiter #(.WORDS(384), .ROWS(48)) dut (
    .clk_25(clk_25), .rst(rst),
    .vid_read(vid_read), .vid_row(vid_row), .vid_addr(vid_addr), .vid_sel(vid_sel),
    .vid_pixel(vid_pixel),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack), .host_err(host_err),
    .clr_start(clr_start), .clr_colour(clr_colour), .clr_busy(clr_busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk_25) if (mem_we) mem[mem_addr] <= mem_wdata;

  always @(negedge clk_25) begin
    if (mem_we && (vid_read || vid_row)) we_bad++;
    if (vid_read && mem_addr !== vid_addr) vid_bad++;
    if (mem_we) we_cnt++;
    if (host_ack) ack_cnt++;
    if (clr_busy) busy_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk_25);
    #1;
  endtask

  typedef struct {
    logic       rd;
    logic       row;
    logic [8:0] addr;
    logic [2:0] sel;
    logic [8:0] exp_addr;
    logic [3:0] exp_pix;
  } vv_t;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [3:0]  wdata;
    int          stall_at;
    int          stall_len;
    int          exp_lat;
    logic        exp_err;
    logic [3:0]  exp_rdata;
    int          exp_writes;
  } hop_t;

  // One host transaction; vid_row is held high for stall_len cycles from stall_at,
  // with vid_read also high on the first stalled cycle.
  task automatic host_op(input hop_t h, input int idx);
    automatic int k = 0;
    automatic int lat = -1;
    automatic int w0, a0;
    automatic bit done = 0;
    host_req = 1'b1; host_we = h.we; host_addr = h.addr; host_wdata = h.wdata;
    w0 = we_cnt; a0 = ack_cnt;
    while (!done && k < 2000) begin
      vid_row  = (h.stall_len > 0) && (k >= h.stall_at) && (k < h.stall_at + h.stall_len);
      vid_read = vid_row && (k == h.stall_at);
      vid_addr = 9'd7;
      @(negedge clk_25);
      if (host_ack) begin
        done = 1;
        lat = k;
        chk($sformatf("hop%0d_err", idx), 32'(host_err), 32'(h.exp_err));
        if (!h.we && !h.exp_err)
          chk($sformatf("hop%0d_rdata", idx), 32'(host_rdata), 32'(h.exp_rdata));
      end else begin
        next_cyc();
        k++;
      end
    end
    chk($sformatf("hop%0d_latency", idx), 32'(lat), 32'(h.exp_lat));
    next_cyc();
    host_req = 1'b0; vid_row = 1'b0; vid_read = 1'b0;
    chk($sformatf("hop%0d_writes", idx), 32'(we_cnt - w0), 32'(h.exp_writes));
    chk($sformatf("hop%0d_acks", idx), 32'(ack_cnt - a0), 32'd1);
  endtask

  vv_t  vv [7];
  hop_t hops [13];

  initial begin
    automatic int a0, b0, bad;
    automatic int k;

    for (int i = 0; i < 512; i++) mem[i] = {16'hC0DE, 16'(i)};

    vv[0] = '{1'b1, 1'b0, 9'd5,     3'd0, 9'd5,     4'h5};
    vv[1] = '{1'b1, 1'b0, 9'd5,     3'd7, 9'd5,     4'hC};
    vv[2] = '{1'b1, 1'b0, 9'h17F,   3'd1, 9'h17F,   4'h7};
    vv[3] = '{1'b1, 1'b1, 9'h1FF,   3'd2, 9'h1FF,   4'h1};
    vv[4] = '{1'b0, 1'b0, 9'd77,    3'd5, 9'd0,     4'hD};
    vv[5] = '{1'b0, 1'b1, 9'd9,     3'd4, 9'd0,     4'hE};
    vv[6] = '{1'b1, 1'b0, 9'd24,    3'd0, 9'd24,    4'h8};

    //          we    addr     wd    st len lat err   rdata writes
    hops[0]  = '{1'b1, 12'h0C7, 4'h5, 0, 0, 3, 1'b0, 4'h0, 1};
    hops[1]  = '{1'b0, 12'h0C7, 4'h0, 0, 0, 2, 1'b0, 4'h5, 0};
    hops[2]  = '{1'b0, 12'h0C0, 4'h0, 0, 0, 2, 1'b0, 4'h8, 0};
    hops[3]  = '{1'b0, 12'h0C5, 4'h0, 0, 0, 2, 1'b0, 4'hD, 0};
    hops[4]  = '{1'b1, 12'hC00, 4'hF, 0, 0, 1, 1'b1, 4'h0, 0};
    hops[5]  = '{1'b0, 12'hFFF, 4'h0, 0, 0, 1, 1'b1, 4'h0, 0};
    hops[6]  = '{1'b0, 12'hBFF, 4'h0, 0, 0, 2, 1'b0, 4'hC, 0};
    hops[7]  = '{1'b1, 12'hBF8, 4'hA, 0, 0, 3, 1'b0, 4'h0, 1};
    hops[8]  = '{1'b0, 12'hBF8, 4'h0, 0, 0, 2, 1'b0, 4'hA, 0};
    hops[9]  = '{1'b1, 12'h0C2, 4'h9, 1, 3, 6, 1'b0, 4'h0, 1};
    hops[10] = '{1'b1, 12'h0C3, 4'h3, 2, 2, 5, 1'b0, 4'h0, 1};
    hops[11] = '{1'b0, 12'h0C3, 4'h0, 1, 2, 4, 1'b0, 4'h3, 0};
    hops[12] = '{1'b0, 12'h0C2, 4'h0, 0, 0, 2, 1'b0, 4'h9, 0};

    rst = 1'b1;
    vid_read = 1'b0; vid_row = 1'b0; vid_addr = '0; vid_sel = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    clr_start = 1'b0; clr_colour = '0;

    @(negedge clk_25);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_host_ack", 32'(host_ack), 32'd0);
    chk("rst_host_err", 32'(host_err), 32'd0);
    chk("rst_host_rdata", 32'(host_rdata), 32'd0);
    chk("rst_clr_busy", 32'(clr_busy), 32'd0);
    next_cyc();
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      vid_read = vv[i].rd; vid_row = vv[i].row; vid_addr = vv[i].addr; vid_sel = vv[i].sel;
      @(negedge clk_25);
      chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vv[i].exp_addr));
      chk($sformatf("vec%0d_vid_pixel", i), 32'(vid_pixel), 32'(vv[i].exp_pix));
      chk($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'd0);
      next_cyc();
    end
    vid_read = 1'b0; vid_row = 1'b0; vid_sel = '0;

    for (int i = 0; i < 13; i++) host_op(hops[i], i);

    chk("mem24_rmw", mem[24], 32'h50DE3918);
    chk("mem23_kept", mem[23], 32'hC0DE0017);
    chk("mem25_kept", mem[25], 32'hC0DE0019);
    chk("mem383_rmw", mem[383], 32'hC0DE017A);
    chk("mem384_kept", mem[384], 32'hC0DE0180);

    // Reset while a write is parked in WR behind vid_row.
    host_req = 1'b1; host_we = 1'b1; host_addr = 12'h004; host_wdata = 4'h1;
    next_cyc();
    next_cyc();
    vid_row = 1'b1;
    @(negedge clk_25);
    chk("rstwr_pre_rdata", 32'(host_rdata), 32'hE);
    chk("rstwr_pre_we", 32'(mem_we), 32'd0);
    a0 = ack_cnt;
    #1 rst = 1'b1;
    #1;
    chk("rstwr_mem_we", 32'(mem_we), 32'd0);
    chk("rstwr_mem_addr", 32'(mem_addr), 32'd0);
    chk("rstwr_mem_wdata", mem_wdata, 32'd0);
    chk("rstwr_host_ack", 32'(host_ack), 32'd0);
    chk("rstwr_host_rdata", 32'(host_rdata), 32'd0);
    chk("rstwr_clr_busy", 32'(clr_busy), 32'd0);
    host_req = 1'b0; vid_row = 1'b0;
    next_cyc();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) next_cyc();
    chk("rstwr_no_ack", 32'(ack_cnt - a0), 32'd0);
    chk("rstwr_mem0_kept", mem[0], 32'hC0DE0000);

`ifdef FB_CLEAR_EN
    // Same-cycle clear and host read: the fill runs first, then the read.
    a0 = ack_cnt;
    clr_start = 1'b1; clr_colour = 4'hA;
    host_req = 1'b1; host_we = 1'b0; host_addr = 12'h0C7;
    @(negedge clk_25);
    chk("clr_busy_c0", 32'(clr_busy), 32'd0);
    next_cyc();
    clr_start = 1'b0; clr_colour = 4'h3;
    @(negedge clk_25);
    chk("clr_busy_c1", 32'(clr_busy), 32'd1);
    k = 1;
    while (clr_busy && k < 1000) begin
      next_cyc();
      k++;
      @(negedge clk_25);
    end
    chk("clr_fall_cycle", 32'(k), 32'd385);
    chk("clr_no_ack_during", 32'(ack_cnt - a0), 32'd0);
    while (!host_ack && k < 1000) begin
      next_cyc();
      k++;
      @(negedge clk_25);
    end
    chk("clr_host_ack_cycle", 32'(k), 32'd387);
    chk("clr_host_rdata", 32'(host_rdata), 32'hA);
    next_cyc();
    host_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 384; i++) if (mem[i] !== 32'hAAAAAAAA) bad++;
    chk("clr_words_bad", 32'(bad), 32'd0);
    chk("clr_mem384_kept", mem[384], 32'hC0DE0180);

    // Second fill with ten stalled cycles, reset just before word 100 is written.
    clr_start = 1'b1; clr_colour = 4'h5;
    for (int i = 1; i <= 111; i++) begin
      next_cyc();
      clr_start = 1'b0;
      vid_row = (i <= 10);
    end
    @(negedge clk_25);
    chk("clr2_addr_w100", 32'(mem_addr), 32'd100);
    chk("clr2_we_w100", 32'(mem_we), 32'd1);
    chk("clr2_wdata", mem_wdata, 32'h55555555);
    #1 rst = 1'b1;
    #1;
    chk("clr2_rst_busy", 32'(clr_busy), 32'd0);
    chk("clr2_rst_we", 32'(mem_we), 32'd0);
    chk("clr2_rst_addr", 32'(mem_addr), 32'd0);
    chk("clr2_rst_wdata", mem_wdata, 32'd0);
    chk("clr2_rst_ack", 32'(host_ack), 32'd0);
    next_cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) next_cyc();
    @(negedge clk_25);
    chk("clr2_idle_busy", 32'(clr_busy), 32'd0);
    bad = 0;
    for (int i = 0; i < 100; i++) if (mem[i] !== 32'h55555555) bad++;
    chk("clr2_low_words_bad", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 100; i < 384; i++) if (mem[i] !== 32'hAAAAAAAA) bad++;
    chk("clr2_high_words_bad", 32'(bad), 32'd0);
    next_cyc();
`else
    // Fill engine absent: clr_start is ignored and the host read proceeds normally.
    b0 = busy_cnt;
    clr_start = 1'b1; clr_colour = 4'hA;
    host_op('{1'b0, 12'h0C7, 4'h0, 0, 0, 2, 1'b0, 4'h5, 0}, 100);
    clr_start = 1'b0;
    chk("noclr_busy_cycles", 32'(busy_cnt - b0), 32'd0);
    chk("noclr_mem0_kept", mem[0], 32'hC0DE0000);
`endif

    chk("mon_we_in_video", 32'(we_bad), 32'd0);
    chk("mon_vid_addr_mux", 32'(vid_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
